// File: rtl/exu_oitf_pkg.sv
// Shared defaults for the outstanding-instruction track FIFO.
// Instantiating modules may override them through parameters.
package exu_oitf_pkg;

    localparam int RFIDX_WIDTH_DEF = 5;
    localparam int PC_SIZE_DEF     = 32;
    localparam int OITF_DEPTH_DEF  = 2;
    localparam int OITF_PTRW_DEF   = $clog2(OITF_DEPTH_DEF);

endpackage

// File: rtl/exu_oitf.sv
// Outstanding Instruction Track FIFO: tracks in-flight long-pipe destinations
// and flags RAW/WAW hazards for the instruction sitting at dispatch.
module exu_oitf
    import exu_oitf_pkg::*;
#(
    parameter int  DEPTH       = OITF_DEPTH_DEF,
    parameter int  RFIDX_WIDTH = RFIDX_WIDTH_DEF,
    parameter int  PC_SIZE     = PC_SIZE_DEF,
    localparam int PTRW        = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   dis_ena,
    output logic                   dis_ready,
    output logic [PTRW-1:0]        dis_ptr,
    input  logic                   disp_i_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
    input  logic [PC_SIZE-1:0]     disp_i_pc,
    input  logic                   disp_i_rs1en,
    input  logic                   disp_i_rs2en,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,

    input  logic                   ret_ena,
    output logic [PTRW-1:0]        ret_ptr,
    output logic                   ret_rdwen,
    output logic [RFIDX_WIDTH-1:0] ret_rdidx,
    output logic [PC_SIZE-1:0]     ret_pc,

    output logic                   oitf_empty,
    output logic                   oitfrd_match_disprs1,
    output logic                   oitfrd_match_disprs2,
    output logic                   oitfrd_match_disprd
);

    localparam logic [PTRW-1:0] LAST = PTRW'(DEPTH - 1);

    logic [DEPTH-1:0]                  vld;
    logic [DEPTH-1:0]                  rdwen;
    logic [DEPTH-1:0][RFIDX_WIDTH-1:0] rdidx;
    logic [DEPTH-1:0][PC_SIZE-1:0]     pc;

    logic [PTRW-1:0] alc_ptr_r, ret_ptr_r;
    logic            alc_flg_r, ret_flg_r;

    logic full, empty, alc_fire, ret_fire;

    assign full     = (alc_ptr_r == ret_ptr_r) && (alc_flg_r != ret_flg_r);
    assign empty    = (alc_ptr_r == ret_ptr_r) && (alc_flg_r == ret_flg_r);
    assign alc_fire = dis_ena & ~full;
    assign ret_fire = ret_ena & ~empty;

    // Pointers wrap at DEPTH-1; the flag distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alc_ptr_r <= '0;
            alc_flg_r <= 1'b0;
        end else if (alc_fire) begin
            if (alc_ptr_r == LAST) begin
                alc_ptr_r <= '0;
                alc_flg_r <= ~alc_flg_r;
            end else begin
                alc_ptr_r <= alc_ptr_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_ptr_r <= '0;
            ret_flg_r <= 1'b0;
        end else if (ret_fire) begin
            if (ret_ptr_r == LAST) begin
                ret_ptr_r <= '0;
                ret_flg_r <= ~ret_flg_r;
            end else begin
                ret_ptr_r <= ret_ptr_r + 1'b1;
            end
        end
    end

    logic [DEPTH-1:0] hit_rs1, hit_rs2, hit_rd;

    // x0 is hardwired zero, so it never carries a real dependency.
    logic src1_nz, src2_nz, dst_nz;
    assign src1_nz = disp_i_rs1en & (disp_i_rs1idx != '0);
    assign src2_nz = disp_i_rs2en & (disp_i_rs2idx != '0);
    assign dst_nz  = disp_i_rdwen & (disp_i_rdidx  != '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic set_i, clr_i;

        // set and clr never coincide: that would need alc_ptr==ret_ptr while
        // neither full nor empty.
        assign set_i = alc_fire & (alc_ptr_r == PTRW'(i));
        assign clr_i = ret_fire & (ret_ptr_r == PTRW'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld[i] <= 1'b0;
            end else if (set_i) begin
                vld[i] <= 1'b1;
            end else if (clr_i) begin
                vld[i] <= 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdwen[i] <= 1'b0;
                rdidx[i] <= '0;
                pc[i]    <= '0;
            end else if (set_i) begin
                rdwen[i] <= disp_i_rdwen;
                rdidx[i] <= disp_i_rdidx;
                pc[i]    <= disp_i_pc;
            end
        end

        // A retiring entry still matches this cycle; vld drops at the edge.
        assign hit_rs1[i] = vld[i] & rdwen[i] & src1_nz & (rdidx[i] == disp_i_rs1idx);
        assign hit_rs2[i] = vld[i] & rdwen[i] & src2_nz & (rdidx[i] == disp_i_rs2idx);
        assign hit_rd[i]  = vld[i] & rdwen[i] & dst_nz  & (rdidx[i] == disp_i_rdidx);
    end

    assign oitfrd_match_disprs1 = |hit_rs1;
    assign oitfrd_match_disprs2 = |hit_rs2;
    assign oitfrd_match_disprd  = |hit_rd;

    assign dis_ready  = ~full;
    assign oitf_empty = empty;
    assign dis_ptr    = alc_ptr_r;
    assign ret_ptr    = ret_ptr_r;
    assign ret_rdwen  = rdwen[ret_ptr_r];
    assign ret_rdidx  = rdidx[ret_ptr_r];
    assign ret_pc     = pc[ret_ptr_r];

endmodule
